clk_freq_meter: RTL

- Measures the frequency of a monitored clock-like signal (`sig_in`, e.g. the divide-by-2 output) against the reference clock `clk_in`.
- Counts rising edges of `sig_in` over a fixed gate window of `clk_in` cycles, then reports the count, an in-tolerance flag and a stuck-signal flag.
- Acts as the receiving/checking end of the clock-divider chain and provides the board-level self-check for divided clocks.

---
 rtl/clk_freq_meter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a fixed
// window of clk_in cycles and reports the count with tolerance/stuck/overflow flags.
module clk_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int EXP_COUNT   = 500,
    parameter int TOL         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             stuck,
    output logic             overflow
);

    localparam int TMR_W  = $clog2(GATE_CYCLES > SYNC_STAGES ? GATE_CYCLES : SYNC_STAGES);
    localparam int DIFF_W = CNT_W + 2;
    localparam logic [TMR_W-1:0]         GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0]         SETTLE_LAST = TMR_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0]         CNT_MAX     = '1;
    localparam logic signed [DIFF_W-1:0] EXP_S       = DIFF_W'(EXP_COUNT);
    localparam logic signed [DIFF_W-1:0] TOL_S       = DIFF_W'(TOL);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic [TMR_W-1:0]       timer;
    logic [CNT_W-1:0]       edge_cnt, cnt_nxt;
    logic                   sat, sat_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && c != CNT_MAX) ? c + 1'b1 : c;
    endfunction

    // One spare bit beyond CNT_W+1 so an EXP_COUNT near 2^CNT_W cannot wrap the difference.
    function automatic logic within_tol(input logic [CNT_W-1:0] c);
        logic signed [DIFF_W-1:0] d;
        d = $signed({2'b00, c}) - EXP_S;
        if (d < 0) d = -d;
        return d <= TOL_S;
    endfunction

    assign rise        = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign cnt_nxt     = sat_inc(edge_cnt, rise);
    assign sat_nxt     = sat | (rise & (edge_cnt == CNT_MAX));
    assign busy        = (state != IDLE);
    assign count_valid = (state == REPORT);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (timer == SETTLE_LAST) state_nxt = GATE;
            GATE:    if (timer == GATE_LAST) state_nxt = REPORT;
            REPORT:  state_nxt = continuous ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE || state == REPORT)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state_nxt == GATE && state != GATE) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == GATE) begin
            edge_cnt <= cnt_nxt;
            sat      <= sat_nxt;
        end
    end

    // Report latch uses the next-count so an edge in the final gate cycle is included.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            stuck    <= 1'b0;
            overflow <= 1'b0;
            in_range <= 1'b0;
        end else if (state == GATE && state_nxt == REPORT) begin
            count    <= cnt_nxt;
            stuck    <= (cnt_nxt == '0);
            overflow <= sat_nxt;
            in_range <= within_tol(cnt_nxt) && !sat_nxt;
        end
    end

endmodule
